// File: rtl/tdm_defs.sv
// Shared definitions for the 4-slot TDM demultiplexer: state encoding, slot width
// and the default loss-of-lock threshold.
package tdm_defs;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;

  localparam int unsigned SlotW            = 2;
  localparam int unsigned MissLimitDefault = 2;
  localparam logic [SlotW-1:0] SlotFirst   = 2'd0;
  localparam logic [SlotW-1:0] SlotLast    = 2'd3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index and missing-marker counter for the TDM demultiplexer.
// Priority: clear > load1 > en.
module tdm_slot_ctr
  import tdm_defs::*;
#(
  parameter int unsigned MISS_LIMIT = MissLimitDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load1,
  input  logic             clear,
  output logic [SlotW-1:0] sel,
  output logic             wrap,
  output logic             miss_hit
);

  localparam int unsigned MissW = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;

  logic [MissW-1:0] miss_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= SlotFirst;
      miss_q <= '0;
    end else if (clear) begin
      sel    <= SlotFirst;
      miss_q <= '0;
    end else if (load1) begin
      sel    <= SlotW'(1);
      miss_q <= '0;
    end else if (en) begin
      sel <= sel + SlotW'(1);
      // Advancing through slot 0 without load1 means the marker was absent.
      if (sel == SlotFirst) begin
        miss_q <= miss_q + MissW'(1);
      end
    end
  end

  assign wrap     = en & ~load1 & ~clear & (sel == SlotLast);
  assign miss_hit = (sel == SlotFirst) & (miss_q == MissW'(MISS_LIMIT - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with frame-marker hunt/lock and flywheel
// tolerance of up to MISS_LIMIT-1 consecutive missing markers.
module tdm_demux4
  import tdm_defs::*;
#(
  parameter int unsigned MISS_LIMIT = MissLimitDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [3:0]       out,
  output logic [SlotW-1:0] sel,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err
);

  state_e     state_q;
  logic [2:0] shadow_q;
  logic       adv;
  logic       load1;
  logic       lost;
  logic       wrap;
  logic       miss_hit;

  // Any enabled marker restarts the frame at slot 1; otherwise only LOCK advances.
  always_comb begin
    adv   = 1'b0;
    load1 = 1'b0;
    if (en) begin
      if (sync) begin
        load1 = 1'b1;
      end else if (state_q == StLock) begin
        adv = 1'b1;
      end
    end
  end

  assign lost   = adv & miss_hit;
  assign locked = (state_q == StLock);

  tdm_slot_ctr #(
    .MISS_LIMIT(MISS_LIMIT)
  ) u_slot_ctr (
    .clk      (clk),
    .rst      (rst),
    .en       (adv),
    .load1    (load1),
    .clear    (lost),
    .sel      (sel),
    .wrap     (wrap),
    .miss_hit (miss_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      shadow_q    <= '0;
      out         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= wrap;
      sync_err    <= 1'b0;
      if (load1) begin
        // A marker away from slot 0 drops the partial frame.
        shadow_q <= {2'b00, din};
        sync_err <= (state_q == StLock) && (sel != SlotFirst);
        state_q  <= StLock;
      end else if (lost) begin
        state_q <= StHunt;
      end else if (wrap) begin
        out <= {din, shadow_q};
      end else if (adv) begin
        shadow_q[sel] <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus pushes expected frames, a monitor
// pops and compares on every frame_valid pulse.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] out;
  logic [1:0] sel;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int failures = 0;
  int serr_exp = 0;
  int serr_seen = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  tdm_demux4 #(
    .MISS_LIMIT(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .en          (en),
    .sync        (sync),
    .out         (out),
    .sel         (sel),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each frame_valid pulse against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid || sync_err) begin
        chk("fv_serr_exclusive", int'(frame_valid && sync_err), 0);
      end
      if (sync_err) serr_seen++;
      if (frame_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", int'(out), -1);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          chk("frame_out", int'(out), int'(e));
        end
      end
    end
  end

  task automatic cyc(input logic e, input logic s, input logic d);
    en = e;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
  endtask

  // b[k] is channel k; gap inserts an en=0 cycle (with sync high) after each bit.
  task automatic send_frame(input logic mark, input logic [3:0] b, input bit gap);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, (k == 0) ? mark : 1'b0, b[k]);
      if (gap) begin
        logic [1:0] s0;
        s0 = sel;
        cyc(1'b0, 1'b1, ~b[k]);
        chk("sel_hold_en_low", int'(sel), int'(s0));
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_out", int'(out), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_serr", int'(sync_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Marker with en low, and unmarked bits, must not lock.
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    chk("hunt_en_low_locked", int'(locked), 0);
    chk("hunt_en_low_sel", int'(sel), 0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1);
    chk("hunt_nosync_locked", int'(locked), 0);
    chk("hunt_out", int'(out), 0);

    // Basic frame 1,0,1,1 -> 4'b1101, one-clock latency.
    exp_q.push_back(4'b1101);
    cyc(1'b1, 1'b1, 1'b1);
    chk("lock_after_sync", int'(locked), 1);
    chk("sel_after_sync", int'(sel), 1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("fv_before_last", int'(frame_valid), 0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("fv_latency", int'(frame_valid), 1);
    chk("out_latency", int'(out), 4'b1101);
    cyc(1'b0, 1'b0, 1'b0);
    chk("fv_pulse_end", int'(frame_valid), 0);

    // Same frame with en toggling.
    exp_q.push_back(4'b1101);
    send_frame(1'b1, 4'b1101, 1'b1);
    chk("gap_fv_no_repeat", int'(frame_valid), 0);

    exp_q.push_back(4'b0110);
    send_frame(1'b1, 4'b0110, 1'b0);

    // Marker at slot 2: error pulse, partial frame dropped, marker bit is new ch0.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    serr_exp++;
    cyc(1'b1, 1'b1, 1'b0);
    chk("serr_pulse", int'(sync_err), 1);
    chk("serr_sel", int'(sel), 1);
    chk("serr_no_fv", int'(frame_valid), 0);
    chk("serr_out_hold", int'(out), 4'b0110);
    exp_q.push_back(4'b1010);
    cyc(1'b1, 1'b0, 1'b1);
    chk("serr_single", int'(sync_err), 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);

    // Two missing markers: first frame flywheels, second drops lock.
    exp_q.push_back(4'b1111);
    send_frame(1'b0, 4'b1111, 1'b0);
    chk("flywheel_locked", int'(locked), 1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("miss_unlock", int'(locked), 0);
    chk("miss_sel", int'(sel), 0);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    chk("hunt_sel_stays", int'(sel), 0);
    chk("hunt_out_hold", int'(out), 4'b1111);

    // Reset mid-frame.
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("pre_rst_sel", int'(sel), 2);
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_out", int'(out), 0);
    chk("async_rst_sel", int'(sel), 0);
    chk("async_rst_locked", int'(locked), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("post_rst_hunt", int'(locked), 0);
    exp_q.push_back(4'b0011);
    send_frame(1'b1, 4'b0011, 1'b0);

    // A marked frame between misses resets the miss count.
    exp_q.push_back(4'b1000);
    send_frame(1'b0, 4'b1000, 1'b0);
    exp_q.push_back(4'b0101);
    send_frame(1'b1, 4'b0101, 1'b0);
    exp_q.push_back(4'b1110);
    send_frame(1'b0, 4'b1110, 1'b0);
    chk("miss_cleared_locked", int'(locked), 1);

    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    chk("frames_pending", exp_q.size(), 0);
    chk("serr_count", serr_seen, serr_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
